multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port opcode, input, 6 bits: instruction register bits [31:26], valid from DECODE onward.
REQ-004 The block SHALL have the port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-005 The block SHALL have the following 1-bit outputs: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst.
REQ-006 The block SHALL have the following 2-bit outputs: PCSource (00 ALU, 01 ALUOut, 10 jump target), ALUOp (00 add, 01 sub, 10 funct), ALUSrcB (00 B, 01 const 4, 10 signext, 11 signext<<2).
REQ-007 The block SHALL have the port illegal_op, output, 1 bit: unrecognised opcode seen in DECODE.
REQ-008 The block SHALL have the port state, output, 4 bits: current FSM state, for debug.

Function
REQ-009 The FSM SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9; codes 10-15 SHALL go to FETCH on the next clock.
REQ-010 Outputs SHALL be Moore outputs decoded from state; only IRWrite and PCWrite in FETCH are additionally gated by mem_ready; every output not listed for a state SHALL be 0.
REQ-011 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, and IRWrite=PCWrite=mem_ready; the FSM SHALL stay in FETCH while mem_ready=0 and go to DECODE otherwise.
REQ-012 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, with next state: R-type (000000) -> EXEC; lw (100011) or sw (101011) -> MEMADR; beq (000100) -> BRANCH; anything else -> FETCH with illegal_op=1 for that cycle.
REQ-013 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEMRD for lw, MEMWR for sw.
REQ-014 MEMRD SHALL drive MemRead=1, IorD=1; the FSM SHALL hold while mem_ready=0, then go to MEMWB.
REQ-015 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0; next state FETCH.
REQ-016 MEMWR SHALL drive MemWrite=1, IorD=1; the FSM SHALL hold while mem_ready=0, then go to FETCH.
REQ-017 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state RWB.
REQ-018 RWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0; next state FETCH.
REQ-019 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next state FETCH.
REQ-020 Instruction latencies, excluding memory wait cycles, SHALL be: lw 5 cycles, sw 4, R-type 4, beq 3, illegal 2.
REQ-021 MemRead and MemWrite SHALL stay asserted for every wait cycle without glitching; a mem_ready pulse outside FETCH, MEMRD or MEMWR SHALL be ignored.
REQ-022 MemRead and MemWrite SHALL never be asserted in the same cycle.

Reset
REQ-023 While rst_n=0, state SHALL be FETCH and all outputs, including IRWrite, PCWrite and MemRead, SHALL be forced to 0.
REQ-024 Reset asserted mid-instruction, including during a memory wait, SHALL abort immediately, with no further register or memory write strobes.
REQ-025 The first fetch SHALL begin on the first clk edge after rst_n deasserts.

Configuration
REQ-026 With JUMP_EN defined, DECODE SHALL send opcode 000010 to JUMP, which drives PCWrite=1 and PCSource=10, next state FETCH (3-cycle latency).
REQ-027 Without JUMP_EN, opcode 000010 SHALL be illegal, and state code 9 SHALL be unused and recover to FETCH.

Structure
REQ-028 Package ctrl_pkg SHALL hold the state enum, the opcode constants (RTYPE, LW, SW, BEQ, J), and the ALUOp, ALUSrcB and PCSource code constants.
REQ-029 Sub-module opcode_decode SHALL be combinational, mapping opcode to one-hot is_rtype, is_lw, is_sw, is_beq, is_j, is_illegal, and the FSM SHALL use only these flags.
REQ-030 The state register and next-state logic SHALL live in multicycle_control.

Verification
REQ-031 After reset release, with mem_ready=1 and opcode=100011, the bench SHALL see the sequence FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH, with RegWrite=MemtoReg=1 only in MEMWB.
REQ-032 With sw and mem_ready held 0 for 3 cycles in MEMWR, the bench SHALL see MemWrite=1 and IorD=1 for 4 cycles, then FETCH.
REQ-033 With beq and mem_ready=1, the bench SHALL see PCWriteCond=1, ALUOp=01 and PCSource=01 for exactly 1 cycle, and a 3-cycle total.
REQ-034 With opcode=111111, the bench SHALL see illegal_op=1 for 1 cycle in DECODE, then FETCH, with no RegWrite or MemWrite.
REQ-035 With rst_n dropped during a MEMRD wait, the bench SHALL see state=0 and all outputs 0 asynchronously, and after release FETCH asserts MemRead=1.
REQ-036 With opcode=000010, the bench SHALL see JUMP with PCSource=10 when JUMP_EN is defined, and illegal_op=1 when it is not.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle datapath controller.
// JUMP_EN enables the jump instruction; without it opcode 000010 is illegal.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } state_e;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_SEXT  = 2'b10;
    localparam logic [1:0] SRCB_SEXT2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier producing one-hot instruction-class flags.
// The jump class is only recognised when JUMP_EN is defined.
module opcode_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_rtype,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_beq,
    output logic       is_j,
    output logic       is_illegal
);

    // Map each opcode to exactly one class flag
    always_comb begin
        is_rtype   = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_j       = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            RTYPE:   is_rtype = 1'b1;
            LW:      is_lw    = 1'b1;
            SW:      is_sw    = 1'b1;
            BEQ:     is_beq   = 1'b1;
`ifdef JUMP_EN
            J:       is_j     = 1'b1;
`endif
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM with Moore outputs decoded from state.
// JUMP_EN adds the JUMP state; otherwise state code 9 recovers to FETCH.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic       illegal_op,
    output logic [3:0] state
);

`ifdef JUMP_EN
    localparam state_e JUMP_TARGET = JUMP;
`else
    localparam state_e JUMP_TARGET = FETCH;
`endif

    state_e state_r;
    state_e next_s;
    ctrl_t  ctrl_s;
    ctrl_t  gated_s;
    logic   is_rtype_s, is_lw_s, is_sw_s, is_beq_s, is_j_s, is_illegal_s;

    opcode_decode u_decode (
        .opcode    (opcode),
        .is_rtype  (is_rtype_s),
        .is_lw     (is_lw_s),
        .is_sw     (is_sw_s),
        .is_beq    (is_beq_s),
        .is_j      (is_j_s),
        .is_illegal(is_illegal_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        next_s = FETCH;
        ctrl_s = '0;
        case (state_r)
            FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.alu_src_b = SRCB_4;
                ctrl_s.ir_write  = mem_ready;
                ctrl_s.pc_write  = mem_ready;
                next_s = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ctrl_s.alu_src_b  = SRCB_SEXT2;
                ctrl_s.illegal_op = is_illegal_s;
                if (is_rtype_s) begin
                    next_s = EXEC;
                end else if (is_lw_s || is_sw_s) begin
                    next_s = MEMADR;
                end else if (is_beq_s) begin
                    next_s = BRANCH;
                end else if (is_j_s) begin
                    next_s = JUMP_TARGET;
                end else begin
                    next_s = FETCH;
                end
            end
            MEMADR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_SEXT;
                if (is_lw_s) begin
                    next_s = MEMRD;
                end else if (is_sw_s) begin
                    next_s = MEMWR;
                end else begin
                    next_s = FETCH;
                end
            end
            MEMRD: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.iord     = 1'b1;
                next_s = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                next_s = FETCH;
            end
            MEMWR: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.iord      = 1'b1;
                next_s = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_B;
                ctrl_s.alu_op    = ALUOP_FUNCT;
                next_s = RWB;
            end
            RWB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.reg_dst   = 1'b1;
                next_s = FETCH;
            end
            BRANCH: begin
                ctrl_s.alu_src_a     = 1'b1;
                ctrl_s.alu_src_b     = SRCB_B;
                ctrl_s.alu_op        = ALUOP_SUB;
                ctrl_s.pc_write_cond = 1'b1;
                ctrl_s.pc_source     = PCSRC_ALUOUT;
                next_s = FETCH;
            end
            JUMP: begin
`ifdef JUMP_EN
                ctrl_s.pc_write  = 1'b1;
                ctrl_s.pc_source = PCSRC_JUMP;
`endif
                next_s = FETCH;
            end
            default: begin
                next_s = FETCH;
            end
        endcase
    end

    // Reset must silence every strobe immediately, not just at the next edge
    assign gated_s     = rst_n ? ctrl_s : '0;
    assign PCWrite     = gated_s.pc_write;
    assign PCWriteCond = gated_s.pc_write_cond;
    assign IorD        = gated_s.iord;
    assign MemRead     = gated_s.mem_read;
    assign MemWrite    = gated_s.mem_write;
    assign MemtoReg    = gated_s.mem_to_reg;
    assign IRWrite     = gated_s.ir_write;
    assign ALUSrcA     = gated_s.alu_src_a;
    assign RegWrite    = gated_s.reg_write;
    assign RegDst      = gated_s.reg_dst;
    assign PCSource    = gated_s.pc_source;
    assign ALUOp       = gated_s.alu_op;
    assign ALUSrcB     = gated_s.alu_src_b;
    assign illegal_op  = gated_s.illegal_op;
    assign state       = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; expected output words are hand-computed.
// Output word order: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,PCSource,ALUOp,ALUSrcB,illegal_op
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] state;
    logic [16:0] outs;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [16:0] O_ZERO     = 17'b0000000000_00_00_00_0;
    localparam logic [16:0] O_FETCH    = 17'b1001001000_00_00_01_0;
    localparam logic [16:0] O_FETCHW   = 17'b0001000000_00_00_01_0;
    localparam logic [16:0] O_DECODE   = 17'b0000000000_00_00_11_0;
    localparam logic [16:0] O_DECILL   = 17'b0000000000_00_00_11_1;
    localparam logic [16:0] O_MEMADR   = 17'b0000000100_00_00_10_0;
    localparam logic [16:0] O_MEMRD    = 17'b0011000000_00_00_00_0;
    localparam logic [16:0] O_MEMWB    = 17'b0000010010_00_00_00_0;
    localparam logic [16:0] O_MEMWR    = 17'b0010100000_00_00_00_0;
    localparam logic [16:0] O_EXEC     = 17'b0000000100_00_10_00_0;
    localparam logic [16:0] O_RWB      = 17'b0000000011_00_00_00_0;
    localparam logic [16:0] O_BRANCH   = 17'b0100000100_01_01_00_0;
    localparam logic [16:0] O_JUMP     = 17'b1000000000_10_00_00_0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .illegal_op(illegal_op), .state(state)
    );

    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, illegal_op};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Step one clock, then sample well away from the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Check state code and full output word after inputs have settled
    task automatic expect_st(input string tag, input logic [3:0] st, input logic [16:0] o);
        #1;
        chk({tag, "_state"}, {13'd0, state}, {13'd0, st});
        chk({tag, "_outs"}, outs, o);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'b100011;
        #2;
        expect_st("reset", 4'd0, O_ZERO);

        @(negedge clk);
        rst_n = 1'b1;
        expect_st("lw_fetch", 4'd0, O_FETCH);
        tick(); expect_st("lw_decode", 4'd1, O_DECODE);
        tick(); expect_st("lw_memadr", 4'd2, O_MEMADR);
        tick(); expect_st("lw_memrd", 4'd3, O_MEMRD);
        tick(); expect_st("lw_memwb", 4'd4, O_MEMWB);
        tick(); expect_st("lw_done", 4'd0, O_FETCH);

        // Fetch stall: IRWrite/PCWrite follow mem_ready
        mem_ready = 1'b0;
        expect_st("fetch_wait", 4'd0, O_FETCHW);
        tick(); expect_st("fetch_hold", 4'd0, O_FETCHW);

        // sw with three wait cycles in MEMWR
        opcode = 6'b101011;
        mem_ready = 1'b1;
        expect_st("sw_fetch", 4'd0, O_FETCH);
        tick(); expect_st("sw_decode", 4'd1, O_DECODE);
        tick(); mem_ready = 1'b0; expect_st("sw_memadr", 4'd2, O_MEMADR);
        tick(); expect_st("sw_wait1", 4'd5, O_MEMWR);
        tick(); expect_st("sw_wait2", 4'd5, O_MEMWR);
        tick(); expect_st("sw_wait3", 4'd5, O_MEMWR);
        tick(); mem_ready = 1'b1; expect_st("sw_last", 4'd5, O_MEMWR);
        tick(); expect_st("sw_done", 4'd0, O_FETCH);

        // R-type; a mem_ready drop in EXEC must be ignored
        opcode = 6'b000000;
        tick(); expect_st("r_decode", 4'd1, O_DECODE);
        tick(); mem_ready = 1'b0; expect_st("r_exec", 4'd6, O_EXEC);
        tick(); mem_ready = 1'b1; expect_st("r_rwb", 4'd7, O_RWB);
        tick(); expect_st("r_done", 4'd0, O_FETCH);

        // beq
        opcode = 6'b000100;
        tick(); expect_st("beq_decode", 4'd1, O_DECODE);
        tick(); expect_st("beq_branch", 4'd8, O_BRANCH);
        tick(); expect_st("beq_done", 4'd0, O_FETCH);

        // illegal opcode
        opcode = 6'b111111;
        tick(); expect_st("ill_decode", 4'd1, O_DECILL);
        tick(); expect_st("ill_done", 4'd0, O_FETCH);

        // jump opcode
        opcode = 6'b000010;
`ifdef JUMP_EN
        tick(); expect_st("j_decode", 4'd1, O_DECODE);
        tick(); expect_st("j_jump", 4'd9, O_JUMP);
        tick(); expect_st("j_done", 4'd0, O_FETCH);
`else
        tick(); expect_st("j_decode_ill", 4'd1, O_DECILL);
        tick(); expect_st("j_done", 4'd0, O_FETCH);
`endif

        // Reset during a MEMRD wait aborts asynchronously
        opcode = 6'b100011;
        tick(); expect_st("rst_decode", 4'd1, O_DECODE);
        tick(); mem_ready = 1'b0; expect_st("rst_memadr", 4'd2, O_MEMADR);
        tick(); expect_st("rst_memrd", 4'd3, O_MEMRD);
        rst_n = 1'b0;
        expect_st("rst_async", 4'd0, O_ZERO);
        tick(); expect_st("rst_held", 4'd0, O_ZERO);
        rst_n = 1'b1;
        expect_st("rst_release", 4'd0, O_FETCHW);
        tick(); expect_st("rst_refetch", 4'd0, O_FETCHW);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
